// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    ODD  = 2'd1,
    EVEN = 2'd2
  } parity_e;

  // Receiver FSM states; prefixed so they never collide with module parameters.
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_HIGH
  } rx_state_e;

  // Width of a counter that must hold 0..clks-1.
  function automatic int timer_w(input int clks);
    return (clks > 1) ? $clog2(clks) : 1;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Free-running bit-period counter; ticks at the half-bit and end-of-bit points.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic half_tick,
  output logic full_tick
);

  localparam int            TW   = timer_w(CLKS_PER_BIT);
  localparam logic [TW-1:0] HALF = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

  logic [TW-1:0] cnt;

  // Count 0..CLKS_PER_BIT-1 and wrap; restart realigns to the current edge.
  always_ff @(posedge clk) begin
    if (reset || restart)  cnt <= '0;
    else if (cnt == LAST)  cnt <= '0;
    else                   cnt <= cnt + 1'b1;
  end

  assign half_tick = (cnt == HALF);
  assign full_tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: synchronizer, framing FSM, shift register and
// a single-entry output register with valid/ready handshake.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam parity_e PAR = parity_e'(PARITY);

  rx_state_e            state, state_n;
  logic                 rx_meta, rx_s;
  logic                 restart, load;
  logic                 half_tick, full_tick;
  logic [DATA_BITS-1:0] shreg;
  logic [3:0]           bit_cnt;
  logic                 stop_cnt;
  logic                 perr_q, ferr_q;
  logic                 par_mismatch;

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk       (clk),
    .reset     (reset),
    .restart   (restart),
    .half_tick (half_tick),
    .full_tick (full_tick)
  );

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk) begin
    if (reset) {rx_s, rx_meta} <= 2'b11;
    else       {rx_s, rx_meta} <= {rx_meta, rx_in};
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  // Next-state logic; timer is held cleared in IDLE and realigned at the
  // start-bit centre so every later full_tick lands on a bit centre.
  always_comb begin
    state_n = state;
    restart = 1'b0;
    load    = 1'b0;
    case (state)
      S_IDLE: begin
        restart = 1'b1;
        if (!rx_s) state_n = S_START;
      end
      S_START: begin
        if (half_tick) begin
          if (!rx_s) begin
            state_n = S_DATA;
            restart = 1'b1;
          end else begin
            state_n = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (full_tick && bit_cnt == 4'(DATA_BITS - 1))
          state_n = (PAR != NONE) ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        if (full_tick) state_n = S_STOP;
      end
      S_STOP: begin
        if (full_tick && stop_cnt == 1'(STOP_BITS - 1)) begin
          load    = 1'b1;
          state_n = rx_s ? S_IDLE : S_WAIT_HIGH;
        end
      end
      S_WAIT_HIGH: begin
        if (rx_s) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Even: parity bit must equal XOR of data; odd: it must differ.
  assign par_mismatch = (PAR == EVEN) ? (rx_s != ^shreg) : (rx_s == ^shreg);

  // Shift register and per-frame error accumulation.
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg    <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      if (state == S_IDLE) begin
        bit_cnt  <= '0;
        stop_cnt <= 1'b0;
        perr_q   <= 1'b0;
        ferr_q   <= 1'b0;
      end
      if (full_tick) begin
        if (state == S_DATA) begin
          shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
          bit_cnt <= bit_cnt + 1'b1;
        end
        if (state == S_PARITY) perr_q <= par_mismatch;
        if (state == S_STOP) begin
          stop_cnt <= stop_cnt + 1'b1;
          if (!rx_s) ferr_q <= 1'b1;
        end
      end
    end
  end

  // Output register: load when empty or being drained, else drop and flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (load && (!data_valid || data_ready)) begin
        data_out   <= shreg;
        frame_err  <= ferr_q | ~rx_s;
        parity_err <= (PAR != NONE) && perr_q;
        data_valid <= 1'b1;
      end else begin
        if (load) overrun <= 1'b1;
        if (data_valid && data_ready) data_valid <= 1'b0;
      end
    end
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench: an 8N1 receiver and a 7E2 receiver, directed scenarios plus random
// frames, checked against a frame-level scoreboard.
module tb_uart_rx_param;

  localparam int CPB = 4;

  typedef struct {
    logic [8:0] data;
    logic       fe;
    logic       pe;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // 8N1 instance
  logic       rx_a = 1'b1, ready_a = 1'b1;
  logic [7:0] dout_a;
  logic       dv_a, fe_a, pe_a, ov_a, busy_a;
  // 7E2 instance
  logic       rx_b = 1'b1, ready_b = 1'b1;
  logic [6:0] dout_b;
  logic       dv_b, fe_b, pe_b, ov_b, busy_b;

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
    .clk(clk), .reset(reset), .rx_in(rx_a), .data_out(dout_a), .data_valid(dv_a),
    .data_ready(ready_a), .frame_err(fe_a), .parity_err(pe_a), .overrun(ov_a), .busy(busy_a));

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) dut_b (
    .clk(clk), .reset(reset), .rx_in(rx_b), .data_out(dout_b), .data_valid(dv_b),
    .data_ready(ready_b), .frame_err(fe_b), .parity_err(pe_b), .overrun(ov_b), .busy(busy_b));

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [8:0] d, input logic fe, input logic pe);
    exp_t e;
    e.data = d; e.fe = fe; e.pe = pe;
    return e;
  endfunction

  // Wire-order frames, bit 0 first.
  function automatic logic [15:0] frame_a(input logic [7:0] d, input logic stop);
    return {6'b111111, stop, d, 1'b0};
  endfunction

  function automatic logic [15:0] frame_b(input logic [6:0] d, input logic p, input logic [1:0] s);
    return {5'b11111, s, p, d, 1'b0};
  endfunction

  // Hold each bit for CPB cycles; line is left at the last bit's level.
  task automatic drive(input bit sel, input logic [15:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      if (sel) rx_b = f[i]; else rx_a = f[i];
      repeat (CPB) @(negedge clk);
    end
  endtask

  // Scoreboard: every accepted word must match the next expected frame.
  exp_t qa[$], qb[$];
  exp_t ea, eb;
  int   ov_cnt_a = 0, rise_a = -1;
  logic dv_a_d = 1'b0;

  always @(negedge clk) begin
    if (!reset) begin
      if (dv_a && ready_a) begin
        if (qa.size() == 0) chk("a_spurious", 1, 0);
        else begin
          ea = qa.pop_front();
          chk("a_data", 32'(dout_a), 32'(ea.data));
          chk("a_fe", 32'(fe_a), 32'(ea.fe));
          chk("a_pe", 32'(pe_a), 32'(ea.pe));
        end
      end
      if (dv_b && ready_b) begin
        if (qb.size() == 0) chk("b_spurious", 1, 0);
        else begin
          eb = qb.pop_front();
          chk("b_data", 32'(dout_b), 32'(eb.data));
          chk("b_fe", 32'(fe_b), 32'(eb.fe));
          chk("b_pe", 32'(pe_b), 32'(eb.pe));
        end
      end
      if (ov_a) ov_cnt_a++;
      if (ov_b) chk("b_overrun", 1, 0);
      if (dv_a && !dv_a_d) rise_a = cyc;
    end
    dv_a_d = dv_a;
  end

  int          c0, ov0, gap;
  logic [7:0]  ra;
  logic [6:0]  rb;
  logic        p, stop;
  logic [1:0]  s;

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    chk("rst_dout_a", 32'(dout_a), 0);
    chk("rst_dv_a", 32'(dv_a), 0);
    chk("rst_fe_a", 32'(fe_a), 0);
    chk("rst_pe_a", 32'(pe_a), 0);
    chk("rst_ov_a", 32'(ov_a), 0);
    chk("rst_busy_a", 32'(busy_a), 0);
    chk("rst_dv_b", 32'(dv_b), 0);
    chk("rst_busy_b", 32'(busy_b), 0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // default 8N1 frame; valid expected after 2 sync cycles, 1 cycle to leave
    // IDLE, half a bit, 9 further bit periods, counted in posedges from the start edge
    qa.push_back(mk(9'h0A5, 1'b0, 1'b0));
    c0 = cyc;
    drive(0, frame_a(8'hA5, 1'b1), 10);
    repeat (2 * CPB) @(negedge clk);
    chk("a5_latency", 32'(rise_a - c0), 32'(3 + CPB / 2 + CPB * 9));
    chk("a5_dv_low", 32'(dv_a), 0);

    // even parity, good then bad parity bit
    qb.push_back(mk(9'h055, 1'b0, 1'b0));
    drive(1, frame_b(7'h55, 1'b0, 2'b11), 11);
    qb.push_back(mk(9'h055, 1'b0, 1'b1));
    drive(1, frame_b(7'h55, 1'b1, 2'b11), 11);
    repeat (2 * CPB) @(negedge clk);

    // framing error followed by a held-low break
    qa.push_back(mk(9'h0C3, 1'b1, 1'b0));
    drive(0, frame_a(8'hC3, 1'b0), 10);
    repeat (3 * CPB) @(negedge clk);
    chk("break_busy", 32'(busy_a), 1);
    rx_a = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    chk("break_idle", 32'(busy_a), 0);
    qa.push_back(mk(9'h05A, 1'b0, 1'b0));
    drive(0, frame_a(8'h5A, 1'b1), 10);
    repeat (2 * CPB) @(negedge clk);

    // single-cycle glitch
    rx_a = 1'b0;
    @(negedge clk);
    rx_a = 1'b1;
    repeat (2) @(negedge clk);
    chk("glitch_busy_hi", 32'(busy_a), 1);
    repeat (2) @(negedge clk);
    chk("glitch_busy_lo", 32'(busy_a), 0);
    repeat (2 * CPB) @(negedge clk);

    // overrun
    ready_a = 1'b0;
    ov0 = ov_cnt_a;
    qa.push_back(mk(9'h011, 1'b0, 1'b0));
    drive(0, frame_a(8'h11, 1'b1), 10);
    drive(0, frame_a(8'h22, 1'b1), 10);
    repeat (2 * CPB) @(negedge clk);
    chk("ovr_dout", 32'(dout_a), 32'h11);
    chk("ovr_dv", 32'(dv_a), 1);
    chk("ovr_pulses", 32'(ov_cnt_a - ov0), 1);
    @(posedge clk);
    #1 ready_a = 1'b1;
    repeat (2) @(negedge clk);
    chk("ovr_drain_dv", 32'(dv_a), 0);

    // reset during data bit 4 of 8'hFF
    fork
      drive(0, frame_a(8'hFF, 1'b1), 10);
      begin
        repeat (5 * CPB + 2) @(negedge clk);
        chk("mid_busy", 32'(busy_a), 1);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_dout", 32'(dout_a), 0);
        chk("mid_rst_dv", 32'(dv_a), 0);
        chk("mid_rst_busy", 32'(busy_a), 0);
        chk("mid_rst_flags", 32'({fe_a, pe_a, ov_a}), 0);
        reset = 1'b0;
      end
    join
    repeat (2 * CPB) @(negedge clk);
    qa.push_back(mk(9'h03C, 1'b0, 1'b0));
    drive(0, frame_a(8'h3C, 1'b1), 10);
    repeat (2 * CPB) @(negedge clk);

    // random frames, including back-to-back and bad stop bits
    for (int i = 0; i < 16; i++) begin
      ra   = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      qa.push_back(mk({1'b0, ra}, ~stop, 1'b0));
      drive(0, frame_a(ra, stop), 10);
      rx_a = 1'b1;
      gap = $urandom_range(0, 3) + (stop ? 0 : CPB);
      repeat (gap) @(negedge clk);
    end
    for (int i = 0; i < 16; i++) begin
      rb = 7'($urandom_range(0, 127));
      p  = 1'($urandom_range(0, 1));
      s  = 2'($urandom_range(0, 3));
      // even parity: total ones over data plus parity bit must be even
      qb.push_back(mk({2'b00, rb}, s != 2'b11, ($countones({rb, p}) % 2) != 0));
      drive(1, frame_b(rb, p, s), 11);
      rx_b = 1'b1;
      gap = $urandom_range(0, 3) + (s[1] ? 0 : CPB);
      repeat (gap) @(negedge clk);
    end

    for (int i = 0; i < 200 && (qa.size() != 0 || qb.size() != 0); i++) @(negedge clk);
    chk("qa_drained", 32'(qa.size()), 0);
    chk("qb_drained", 32'(qb.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised UART receiver, the successor to the fixed 8-bit receiver. It converts an asynchronous serial line into parallel words, with configurable word length, parity, stop bits and bit period. It adds mid-bit sampling with start-bit validation, framing/parity/overrun error reporting, and a valid/ready output handshake. It sits between the pad-side `rx_in` and any downstream FIFO or register file.

## Interface
- `CLKS_PER_BIT`, 16: clk cycles per serial bit, ≥4.
- `DATA_BITS`, 8: payload width, 5..9.
- `PARITY`, 0: 0 none, 1 odd, 2 even.
- `STOP_BITS`, 1: 1 or 2.
- `clk` in 1: single clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `rx_in` in 1: asynchronous serial input, idle high.
- `data_out` out DATA_BITS: received word, LSB is the first bit on the wire.
- `data_valid` out 1: `data_out` and the error flags hold a word.
- `data_ready` in 1: consumer accepts the word when `data_valid && data_ready`.
- `frame_err` out 1: stop bit sampled low, qualified by `data_valid`.
- `parity_err` out 1: parity mismatch, qualified by `data_valid`; always 0 when PARITY=0.
- `overrun` out 1: one-cycle pulse when a completed word is dropped.
- `busy` out 1: receiver FSM is not in IDLE.

## Operation
- `rx_in` passes through a 2-FF synchronizer (reset value 1). All sampling uses the synchronized value `rx_s`.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
- **IDLE:**
  - `rx_s`=0 → START; bit timer cleared.
- **START:**
  - At count CLKS_PER_BIT/2−1, if `rx_s`=0 → DATA with the timer restarted.
  - Otherwise it was a glitch → IDLE, and no word is produced.
- **DATA:**
  - Sample `rx_s` every CLKS_PER_BIT cycles, i.e. at each bit centre.
  - Shift right into the shift register; after DATA_BITS samples go to PARITY if PARITY≠0, else STOP.
- **PARITY:**
  - Sample one bit and compute the expected parity: even → XOR of data = parity bit; odd → XOR of data ≠ parity bit.
  - Mismatch latches `parity_err`. Then → STOP.
- **STOP:**
  - Sample STOP_BITS bits; any low sample sets the frame error.
  - After the last stop-bit sample, load the output register, then → IDLE.
  - If the last sample was low, go to WAIT_HIGH instead.
- **WAIT_HIGH:** stay until `rx_s`=1 (break/stuck-low handling), then → IDLE. No new start is detected while in this state.
- **Output register:**
  - If `data_valid`=0 (or it is being accepted in the same cycle), load `data_out`/`frame_err`/`parity_err` and set `data_valid`.
  - Otherwise discard the new word, keep the old one, and pulse `overrun` for 1 cycle.
- `data_valid` clears on the cycle after a handshake unless a new word loads in that same cycle (simultaneous accept + load → `data_valid` stays 1 with the new data).
- `data_out` holds its value after acceptance; it is not cleared.

## Timing
- Reset values:
  - `data_out`=0, `data_valid`=0, `frame_err`=0, `parity_err`=0, `overrun`=0, `busy`=0.
  - FSM in IDLE, synchronizer at 1.
- Reset mid-frame aborts the frame at the next edge; the partial word is never output.
- Synchronizer latency: 2 cycles.
- START validation occurs CLKS_PER_BIT/2 cycles after the falling edge is seen on `rx_s`.
- `data_valid` rises 1 cycle after the final stop-bit centre sample.
- Frame length: 1+DATA_BITS+(PARITY≠0)+STOP_BITS bit periods.
- Back-to-back frames are accepted: IDLE is re-entered at the final stop-bit centre, so the next start edge may arrive half a bit later.
- Tolerates ±(50/frame_bits)% baud mismatch; this is not checked in RTL.

## Structure
- Package `uart_pkg`: `parity_e` enum (NONE, ODD, EVEN), `rx_state_e` FSM typedef, and a `clog2`-based width constant for the bit timer.
- Sub-module `uart_bit_timer`:
  - Inputs: `clk`, `reset`, `restart`.
  - Outputs: `half_tick` and `full_tick`.
  - Parameter: CLKS_PER_BIT.
- Synchronizer, FSM, shift register and output register live in `uart_rx_param`.

## Test plan
- Use CLKS_PER_BIT=4 unless stated otherwise.
- **Default frame:** 8N1, byte 8'hA5 sent LSB first, `data_ready`=1 → `data_valid` for 1 cycle with `data_out`=8'hA5, no errors, 1 cycle after the stop-bit centre.
- **Parity:** PARITY=2 (even), DATA_BITS=7, word 7'h55 with correct parity bit 0 → `parity_err`=0. Same word with parity bit 1 → `parity_err`=1 and `data_out`=7'h55.
- **Framing/break:** stop bit driven 0, then line held low for 3 bit periods → `frame_err`=1 with `data_valid`. No second word appears until `rx_in` returns high and a fresh start bit arrives.
- **Glitch:** `rx_in` low for 1 cycle only → START aborts, `data_valid` never rises, and `busy` returns to 0 within 4 cycles.
- **Overrun:** `data_ready`=0, send 8'h11 then 8'h22 back-to-back → `data_out` stays 8'h11 and `overrun` pulses once. Raising `data_ready` then drops `data_valid`.
- **Reset mid-frame:** assert `reset` for 1 cycle during bit 4 of 8'hFF → all outputs return to reset values. A following frame of 8'h3C is received correctly.
